// File: rtl/rom_rd_pkg.sv
// Shared types and helpers for the ROM burst read sequencer.
package rom_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] KEEP_LO   = 2'b01;
    localparam logic [1:0] KEEP_BOTH = 2'b11;

    function automatic logic [31:0] clamp_len(input logic [31:0] len, input logic [31:0] depth);
        return (len > depth) ? depth : len;
    endfunction

endpackage

// File: rtl/async_dual_port_rom.sv
// Dual read-port ROM with computed contents; combinational or registered read data.
module async_dual_port_rom #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int INIT_PATTERN   = 0,
    parameter int REGISTERED_OUT = 0
) (
    input  logic                  clk,
    input  logic                  read_en_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    output logic [DATA_WIDTH-1:0] data_a,
    input  logic                  read_en_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] data_b
);

    // Pattern 1 stores x*x+x, anything else stores the address itself.
    function automatic logic [DATA_WIDTH-1:0] word_at(input logic [ADDR_WIDTH-1:0] a);
        logic [31:0] v;
        v = 32'(a);
        if (INIT_PATTERN == 1)
            return DATA_WIDTH'(v * v + v);
        return DATA_WIDTH'(v);
    endfunction

    logic [DATA_WIDTH-1:0] comb_a, comb_b, reg_a, reg_b;

    assign comb_a = read_en_a ? word_at(addr_a) : '0;
    assign comb_b = read_en_b ? word_at(addr_b) : '0;

    always_ff @(posedge clk) begin
        if (read_en_a) reg_a <= word_at(addr_a);
        if (read_en_b) reg_b <= word_at(addr_b);
    end

    assign data_a = (REGISTERED_OUT != 0) ? reg_a : comb_a;
    assign data_b = (REGISTERED_OUT != 0) ? reg_b : comb_b;

endmodule

// File: rtl/rom_beat_reg.sv
// Output holding register: a beat stays frozen until the downstream accepts it.
module rom_beat_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic [2*DATA_WIDTH-1:0] in_data,
    input  logic [1:0]              in_keep,
    input  logic                    in_last,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [2*DATA_WIDTH-1:0] out_data,
    output logic [1:0]              out_keep,
    output logic                    out_last
);

    // load is only raised when the slot is empty or being drained this edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_keep  <= in_keep;
            out_last  <= in_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rom_burst_reader.sv
// Burst sequencer fetching two consecutive ROM words per cycle into a valid/ready stream.
module rom_burst_reader
    import rom_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int MEM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   start_addr,
    input  logic [ADDR_WIDTH:0]     burst_len,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   rom_addr_a,
    output logic                    rom_read_en_a,
    input  logic [DATA_WIDTH-1:0]   rom_data_a,
    output logic [ADDR_WIDTH-1:0]   rom_addr_b,
    output logic                    rom_read_en_b,
    input  logic [DATA_WIDTH-1:0]   rom_data_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] out_data,
    output logic [1:0]              out_keep,
    output logic                    out_last
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, addr_a_q, addr_b_q;
    logic [ADDR_WIDTH:0]   rem_q, rem_start;
    logic                  load, two_left, last_beat;

    assign rem_start = (ADDR_WIDTH+1)'(clamp_len(32'(burst_len), 32'(MEM_DEPTH)));
    assign two_left  = rem_q >= (ADDR_WIDTH+1)'(2);
    assign last_beat = rem_q <= (ADDR_WIDTH+1)'(2);
    assign load      = (state_q == READ) && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (rem_start == '0) ? DONE : READ;
            READ:    if (load && last_beat) state_d = DRAIN;
            DRAIN:   if (out_valid && out_ready) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Addresses are live during a load and otherwise hold the last issued pair.
    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        rom_read_en_a = 1'b0;
        rom_read_en_b = 1'b0;
        rom_addr_a    = addr_a_q;
        rom_addr_b    = addr_b_q;
        case (state_q)
            READ: begin
                busy = 1'b1;
                if (load) begin
                    rom_read_en_a = 1'b1;
                    rom_read_en_b = two_left;
                    rom_addr_a    = ptr_q;
                    rom_addr_b    = ptr_q + ADDR_WIDTH'(1);
                end
            end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q    <= '0;
            rem_q    <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
        end else if (state_q == IDLE && start) begin
            ptr_q <= start_addr;
            rem_q <= rem_start;
        end else if (load) begin
            ptr_q    <= ptr_q + ADDR_WIDTH'(2);
            rem_q    <= two_left ? rem_q - (ADDR_WIDTH+1)'(2) : '0;
            addr_a_q <= ptr_q;
            addr_b_q <= ptr_q + ADDR_WIDTH'(1);
        end
    end

    rom_beat_reg #(.DATA_WIDTH(DATA_WIDTH)) u_beat (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .in_data   ({two_left ? rom_data_b : {DATA_WIDTH{1'b0}}, rom_data_a}),
        .in_keep   (two_left ? KEEP_BOTH : KEEP_LO),
        .in_last   (last_beat),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last)
    );

endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed bench for rom_burst_reader driving the x*x+x ROM.
module tb_rom_burst_reader;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   burst_len;
    logic          busy, done;
    logic [AW-1:0] rom_addr_a, rom_addr_b;
    logic          rom_read_en_a, rom_read_en_b;
    logic [DW-1:0] rom_data_a, rom_data_b;
    logic          out_valid, out_ready, out_last;
    logic [2*DW-1:0] out_data;
    logic [1:0]    out_keep;

    always #5 clk = ~clk;

    async_dual_port_rom #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_PATTERN(1), .REGISTERED_OUT(0)) u_rom (
        .clk(clk), .read_en_a(rom_read_en_a), .addr_a(rom_addr_a), .data_a(rom_data_a),
        .read_en_b(rom_read_en_b), .addr_b(rom_addr_b), .data_b(rom_data_b)
    );

    rom_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr), .burst_len(burst_len),
        .busy(busy), .done(done),
        .rom_addr_a(rom_addr_a), .rom_read_en_a(rom_read_en_a), .rom_data_a(rom_data_a),
        .rom_addr_b(rom_addr_b), .rom_read_en_b(rom_read_en_b), .rom_data_b(rom_data_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_keep(out_keep), .out_last(out_last)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] bd[32];
    logic [1:0]  bk[32];
    logic        bl[32];
    logic [3:0]  addr_log[64];
    logic        ena_log[64];
    logic        enb_log[64];
    int nb, nd, nvalid, done_cyc, first_cyc, last_acc_cyc;

    function automatic logic [7:0] w(input int a);
        int m;
        m = a % 16;
        return 8'(m * m + m);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_burst(input logic [AW-1:0] a, input logic [AW:0] len);
        #1;
        start      = 1'b1;
        start_addr = a;
        burst_len  = len;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Runs ncyc cycles, recording accepted beats, done pulses and port activity.
    task automatic collect(input int ncyc, input int stall_at, input int stall_n, input int poke_at);
        int stalled;
        bit stall_prev;
        logic [15:0] pd;
        logic [1:0]  pk;
        logic        pl;
        stalled = 0; stall_prev = 0; pd = '0; pk = '0; pl = 1'b0;
        nb = 0; nd = 0; nvalid = 0; done_cyc = -1; first_cyc = -1; last_acc_cyc = -1;
        for (int i = 0; i < 32; i++) begin bd[i] = 'x; bk[i] = 'x; bl[i] = 1'bx; end
        for (int c = 0; c < ncyc; c++) begin
            #1;
            if (c == poke_at) begin
                start = 1'b1; start_addr = 4'd9; burst_len = 5'd2;
            end else begin
                start = 1'b0;
            end
            out_ready = !(stall_at >= 0 && nb == stall_at && out_valid && stalled < stall_n);
            #1;
            addr_log[c] = rom_addr_a; ena_log[c] = rom_read_en_a; enb_log[c] = rom_read_en_b;
            if (!out_ready) begin
                stalled++;
                chk("stall_en_a", 32'(rom_read_en_a), 32'd0);
                chk("stall_en_b", 32'(rom_read_en_b), 32'd0);
                if (stall_prev) begin
                    chk("stall_data", 32'(out_data), 32'(pd));
                    chk("stall_keep", 32'(out_keep), 32'(pk));
                    chk("stall_last", 32'(out_last), 32'(pl));
                end
                pd = out_data; pk = out_keep; pl = out_last;
                stall_prev = 1'b1;
            end else begin
                stall_prev = 1'b0;
            end
            if (out_valid) nvalid++;
            if (out_valid && out_ready && nb < 32) begin
                bd[nb] = out_data; bk[nb] = out_keep; bl[nb] = out_last;
                if (nb == 0) first_cyc = c;
                last_acc_cyc = c;
                nb++;
            end
            if (done) begin nd++; done_cyc = c; end
            @(posedge clk);
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; start_addr = '0; burst_len = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_en_a", 32'(rom_read_en_a), 32'd0);
        chk("rst_addr_b", 32'(rom_addr_b), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);

        // Aligned 4-word burst
        start_burst(4'd0, 5'd4);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_en_a", 32'(rom_read_en_a), 32'd1);
        chk("t1_addr_a", 32'(rom_addr_a), 32'd0);
        chk("t1_addr_b", 32'(rom_addr_b), 32'd1);
        chk("t1_valid0", 32'(out_valid), 32'd0);
        collect(8, -1, 0, -1);
        chk("t1_nbeats", 32'(nb), 32'd2);
        chk("t1_beat0", 32'(bd[0]), 32'h0200);
        chk("t1_keep0", 32'(bk[0]), 32'h3);
        chk("t1_last0", 32'(bl[0]), 32'd0);
        chk("t1_beat1", 32'(bd[1]), 32'h0C06);
        chk("t1_keep1", 32'(bk[1]), 32'h3);
        chk("t1_last1", 32'(bl[1]), 32'd1);
        chk("t1_first", 32'(first_cyc), 32'd1);
        chk("t1_ndone", 32'(nd), 32'd1);
        chk("t1_done_at", 32'(done_cyc), 32'(last_acc_cyc + 1));
        chk("t1_idle", 32'(busy), 32'd0);

        // Wrapping odd-length burst
        start_burst(4'd14, 5'd3);
        collect(8, -1, 0, -1);
        chk("t2_nbeats", 32'(nb), 32'd2);
        chk("t2_beat0", 32'(bd[0]), 32'hF0D2);
        chk("t2_keep0", 32'(bk[0]), 32'h3);
        chk("t2_last0", 32'(bl[0]), 32'd0);
        chk("t2_beat1", 32'(bd[1]), 32'h0000);
        chk("t2_keep1", 32'(bk[1]), 32'h1);
        chk("t2_last1", 32'(bl[1]), 32'd1);
        chk("t2_addr0", 32'(addr_log[0]), 32'd14);
        chk("t2_addr_wrap", 32'(addr_log[1]), 32'd0);
        chk("t2_en_b1", 32'(enb_log[1]), 32'd0);
        chk("t2_ndone", 32'(nd), 32'd1);

        // Downstream stall on the second beat
        start_burst(4'd3, 5'd5);
        collect(12, 1, 3, -1);
        chk("t3_nbeats", 32'(nb), 32'd3);
        chk("t3_beat0", 32'(bd[0]), 32'h140C);
        chk("t3_beat1", 32'(bd[1]), 32'h2A1E);
        chk("t3_beat2", 32'(bd[2]), 32'h0038);
        chk("t3_keep2", 32'(bk[2]), 32'h1);
        chk("t3_last1", 32'(bl[1]), 32'd0);
        chk("t3_last2", 32'(bl[2]), 32'd1);
        chk("t3_ndone", 32'(nd), 32'd1);

        // Zero-length burst
        start_burst(4'd5, 5'd0);
        collect(6, -1, 0, -1);
        chk("t4_nvalid", 32'(nvalid), 32'd0);
        chk("t4_ndone", 32'(nd), 32'd1);
        chk("t4_done_at", 32'(done_cyc), 32'd0);
        chk("t4_en_a", 32'(ena_log[0]), 32'd0);

        // Over-length burst is clamped to the ROM depth
        start_burst(4'd0, 5'd20);
        collect(14, -1, 0, -1);
        chk("t5_nbeats", 32'(nb), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("t5_beat", 32'(bd[i]), 32'({w(2 * i + 1), w(2 * i)}));
            chk("t5_keep", 32'(bk[i]), 32'h3);
            chk("t5_last", 32'(bl[i]), 32'(i == 7));
        end
        chk("t5_ndone", 32'(nd), 32'd1);

        // Reset in the middle of a burst
        start_burst(4'd2, 5'd8);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_data", 32'(out_data), 32'd0);
        chk("t6_keep", 32'(out_keep), 32'd0);
        chk("t6_last", 32'(out_last), 32'd0);
        chk("t6_en_a", 32'(rom_read_en_a), 32'd0);
        chk("t6_addr_a", 32'(rom_addr_a), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        collect(6, -1, 0, -1);
        chk("t6_post_done", 32'(nd), 32'd0);
        chk("t6_post_valid", 32'(nvalid), 32'd0);
        start_burst(4'd8, 5'd4);
        collect(8, -1, 0, -1);
        chk("t6_nbeats", 32'(nb), 32'd2);
        chk("t6_beat0", 32'(bd[0]), 32'h5A48);
        chk("t6_beat1", 32'(bd[1]), 32'h846E);
        chk("t6_ndone", 32'(nd), 32'd1);

        // Start while busy is ignored
        start_burst(4'd0, 5'd6);
        collect(10, -1, 0, 1);
        chk("t7_nbeats", 32'(nb), 32'd3);
        chk("t7_beat0", 32'(bd[0]), 32'h0200);
        chk("t7_beat1", 32'(bd[1]), 32'h0C06);
        chk("t7_beat2", 32'(bd[2]), 32'h1E14);
        chk("t7_last2", 32'(bl[2]), 32'd1);
        chk("t7_ndone", 32'(nd), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
